// File: rtl/fetch_redirect_unit_if.sv
// Purpose: groups the EX-stage control-flow results and the fetch outputs of the redirect unit.
// Latency: none; this is wiring only.
// Backpressure: Stall is the only hold signal, driven by the hazard side through the master modport.
interface fetch_redirect_unit_if #(
  parameter int NBits = 32,
  parameter int CNT_W = 16
);
  logic             Stall;
  logic             BranchEQ;
  logic             BranchNE;
  logic             Jump;
  logic             JumpRegister;
  logic             Zero;
  logic [NBits-1:0] EX_PC_4;
  logic [NBits-1:0] BranchAddress;
  logic [NBits-1:0] JumpAddress;
  logic [NBits-1:0] JumpRegAddress;
  logic [NBits-1:0] PC;
  logic [NBits-1:0] PC_4;
  logic             Flush_IFID;
  logic             Flush_IDEX;
  logic             RedirectPending;
  logic             AddrMisaligned;
  logic [CNT_W-1:0] RedirectCount;

  // EX stage / hazard unit side
  modport master (
    output Stall, BranchEQ, BranchNE, Jump, JumpRegister, Zero,
           EX_PC_4, BranchAddress, JumpAddress, JumpRegAddress,
    input  PC, PC_4, Flush_IFID, Flush_IDEX, RedirectPending,
           AddrMisaligned, RedirectCount
  );

  // Fetch redirect unit side
  modport slave (
    input  Stall, BranchEQ, BranchNE, Jump, JumpRegister, Zero,
           EX_PC_4, BranchAddress, JumpAddress, JumpRegAddress,
    output PC, PC_4, Flush_IFID, Flush_IDEX, RedirectPending,
           AddrMisaligned, RedirectCount
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Purpose: owns the PC, resolves EX branches/jumps into redirects and IF/ID + ID/EX flushes.
// Latency: redirect visible in PC one edge after EX resolves, or on the first edge after Stall drops.
// Backpressure: Stall holds the PC; a redirect seen under Stall is latched and the oldest one wins.
module fetch_redirect_unit #(
  parameter int               NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = 32'h00400000,
  parameter int               CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  fetch_redirect_unit_if.slave bus
);

  typedef enum logic {RUN, PENDING} state_t;

  state_t           state;
  logic [NBits-1:0] pcReg;
  logic [NBits-1:0] pcPlus4;
  logic [NBits-1:0] pendingTarget;
  logic [NBits-1:0] target;
  logic [NBits-1:0] applyTarget;
  logic             taken;
  logic             req;
  logic             apply;
  logic             misaligned;
  logic [CNT_W-1:0] redirectCnt;

  // Resolve the EX request and decide whether a redirect lands on the coming edge
  always_comb begin
    taken = (bus.BranchEQ & bus.Zero) | (bus.BranchNE & ~bus.Zero);
    req   = bus.JumpRegister | bus.Jump | taken;
    if (bus.JumpRegister) begin
      target = bus.JumpRegAddress;
    end else if (bus.Jump) begin
      target = {bus.EX_PC_4[NBits-1:NBits-4], bus.JumpAddress[NBits-5:0]};
    end else begin
      target = bus.BranchAddress;
    end
    // A latched redirect is older than anything currently in EX, so it takes precedence
    apply       = ~bus.Stall & ((state == PENDING) | req);
    applyTarget = (state == PENDING) ? pendingTarget : target;
    pcPlus4     = pcReg + NBits'(4);
  end

  // PC / deferral FSM with sticky misalignment flag and saturating redirect counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      pcReg         <= RESET_PC;
      pendingTarget <= '0;
      misaligned    <= 1'b0;
      redirectCnt   <= '0;
    end else begin
      if (apply) begin
        pcReg <= {applyTarget[NBits-1:2], 2'b00};
        state <= RUN;
        if (applyTarget[1:0] != 2'b00) begin
          misaligned <= 1'b1;
        end
        if (redirectCnt != {CNT_W{1'b1}}) begin
          redirectCnt <= redirectCnt + 1'b1;
        end
      end else if (bus.Stall) begin
        // Under stall only the first redirect is captured; later ones are dropped
        if ((state == RUN) && req) begin
          pendingTarget <= target;
          state         <= PENDING;
        end
      end else begin
        pcReg <= pcPlus4;
      end
    end
  end

  // Drive the fetch-side outputs
  always_comb begin
    bus.PC              = pcReg;
    bus.PC_4            = pcPlus4;
    bus.Flush_IFID      = apply;
    bus.Flush_IDEX      = apply;
    bus.RedirectPending = (state == PENDING);
    bus.AddrMisaligned  = misaligned;
    bus.RedirectCount   = redirectCnt;
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Purpose: scoreboard bench for fetch_redirect_unit against a cycle-level reference model.
// Latency: expectations are taken per cycle; outputs sampled two time units after the falling edge.
// Backpressure: Stall is exercised both directed and at random.
module tb_fetch_redirect_unit;

  typedef struct {
    logic        stall, beq, bne, jmp, jr, zero;
    logic [31:0] exPc4, brAddr, jAddr, jrAddr;
  } stim_t;

  typedef struct {
    logic [31:0] pc, pc4;
    logic        flush, pend, mis;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nCmp = 0;
  int   nBad = 0;
  exp_t expQ[$];

  // reference model state
  logic [31:0] mPc;
  bit          mPend;
  logic [31:0] mPendTgt;
  bit          mMis;
  int          mCnt;

  fetch_redirect_unit_if #(.NBits(32), .CNT_W(16)) bus ();
  fetch_redirect_unit_if #(.NBits(32), .CNT_W(2))  bus2 ();

  fetch_redirect_unit #(.NBits(32), .RESET_PC(32'h00400000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_redirect_unit #(.NBits(32), .RESET_PC(32'h00400000), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nCmp++;
    if (act !== want) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.Stall = s.stall;        bus2.Stall = s.stall;
    bus.BranchEQ = s.beq;       bus2.BranchEQ = s.beq;
    bus.BranchNE = s.bne;       bus2.BranchNE = s.bne;
    bus.Jump = s.jmp;           bus2.Jump = s.jmp;
    bus.JumpRegister = s.jr;    bus2.JumpRegister = s.jr;
    bus.Zero = s.zero;          bus2.Zero = s.zero;
    bus.EX_PC_4 = s.exPc4;      bus2.EX_PC_4 = s.exPc4;
    bus.BranchAddress = s.brAddr;   bus2.BranchAddress = s.brAddr;
    bus.JumpAddress = s.jAddr;      bus2.JumpAddress = s.jAddr;
    bus.JumpRegAddress = s.jrAddr;  bus2.JumpRegAddress = s.jrAddr;
  endtask

  function automatic exp_t snapshot(input bit flush);
    exp_t e;
    e.pc    = mPc;
    e.pc4   = mPc + 32'd4;
    e.flush = flush;
    e.pend  = mPend;
    e.mis   = mMis;
    e.cnt   = (mCnt > 65535) ? 16'hFFFF : 16'(mCnt);
    e.cnt2  = (mCnt > 3) ? 2'd3 : 2'(mCnt);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // One clock of stimulus: drive, record what the DUT must show, then advance the model
  task automatic step(input stim_t s);
    bit          req, doApply;
    logic [31:0] tgt, appTgt;
    @(negedge clk);
    reset = 1'b1;
    drive(s);
    req = s.jr || s.jmp || (s.beq && s.zero) || (s.bne && !s.zero);
    if (s.jr)       tgt = s.jrAddr;
    else if (s.jmp) tgt = {s.exPc4[31:28], s.jAddr[27:0]};
    else            tgt = s.brAddr;
    doApply = !s.stall && (mPend || req);
    appTgt  = mPend ? mPendTgt : tgt;
    expQ.push_back(snapshot(doApply));
    if (doApply) begin
      mPc   = appTgt & ~32'd3;
      mPend = 0;
      if (appTgt[1:0] != 2'b00) mMis = 1;
      mCnt++;
    end else if (s.stall) begin
      if (!mPend && req) begin
        mPend    = 1;
        mPendTgt = tgt;
      end
    end else begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    drive(idle());
    mPc = 32'h00400000; mPend = 0; mPendTgt = 0; mMis = 0; mCnt = 0;
    expQ.push_back(snapshot(1'b0));
  endtask

  // Monitor: whenever an expectation is queued, compare it with what the DUTs present
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("PC", bus.PC, e.pc);
        chk("PC_4", bus.PC_4, e.pc4);
        chk("Flush_IFID", 32'(bus.Flush_IFID), 32'(e.flush));
        chk("Flush_IDEX", 32'(bus.Flush_IDEX), 32'(e.flush));
        chk("RedirectPending", 32'(bus.RedirectPending), 32'(e.pend));
        chk("AddrMisaligned", 32'(bus.AddrMisaligned), 32'(e.mis));
        chk("RedirectCount", 32'(bus.RedirectCount), 32'(e.cnt));
        chk("RedirectCount_w2", 32'(bus2.RedirectCount), 32'(e.cnt2));
      end
    end
  end

  initial begin
    stim_t s;
    drive(idle());
    doReset();
    // reset release and free-running fetch
    repeat (3) step(idle());
    // taken beq, then untaken beq
    s = idle(); s.beq = 1; s.zero = 1; s.brAddr = 32'h00400040; step(s);
    step(idle());
    s.zero = 0; step(s);
    step(idle());
    // j, then jr taking priority over j
    s = idle(); s.jmp = 1; s.exPc4 = 32'h10000008; s.jAddr = 32'h00000100; step(s);
    step(idle());
    s.jr = 1; s.jrAddr = 32'h00400200; step(s);
    step(idle());
    // redirect under stall, newer request while pending, stall drops with a request present
    s = idle(); s.stall = 1; s.beq = 1; s.zero = 1; s.brAddr = 32'h00400080; step(s);
    s = idle(); s.stall = 1; step(s);
    s.jmp = 1; s.exPc4 = 32'h20000000; s.jAddr = 32'h00000300; step(s);
    s.stall = 0; step(s);
    step(idle());
    step(idle());
    // reset while pending discards the latched target
    s = idle(); s.stall = 1; s.jr = 1; s.jrAddr = 32'h00400500; step(s);
    doReset();
    repeat (3) step(idle());
    // misaligned target, then enough redirects to saturate the narrow counter
    s = idle(); s.jr = 1; s.jrAddr = 32'h00400103; step(s);
    step(idle());
    step(idle());
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.jr = 1; s.jrAddr = 32'h00400000 + 32'(i * 16); step(s);
    end
    step(idle());
    // PC wrap at the top of the address space
    s = idle(); s.jr = 1; s.jrAddr = 32'hFFFFFFFC; step(s);
    step(idle());
    step(idle());
    // randomized traffic with occasional resets
    doReset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        s.stall  = ($urandom_range(0, 3) == 0);
        s.beq    = ($urandom_range(0, 3) == 0);
        s.bne    = ($urandom_range(0, 3) == 0);
        s.jmp    = ($urandom_range(0, 7) == 0);
        s.jr     = ($urandom_range(0, 7) == 0);
        s.zero   = 1'($urandom_range(0, 1));
        s.exPc4  = $urandom() & ~32'd3;
        s.brAddr = $urandom() & ~32'd3;
        s.jAddr  = $urandom() & ~32'd3;
        s.jrAddr = $urandom();
        if ($urandom_range(0, 15) != 0) s.jrAddr = s.jrAddr & ~32'd3;
        step(s);
      end
    end
    @(negedge clk);
    #5;
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
